exc_ctrl: RTL and testbench

MEM-stage exception collector and prioritiser; it is the source side of the exception interface consumed by the CP0 register block. Each cycle it merges per-instruction fault flags, locally detected address errors and masked interrupts into one exception code. It also produces bad address, PC and delay-slot flag for CP0, and synchronises external interrupt lines into the CP0 interrupt vector. CP0 turns a non-`EXC_NONE` code into flush and handler address the same cycle.

---
 rtl/exc_ctrl.sv | 127 ++++++++++++
 tb/tb_exc_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// MEM-stage exception collector: merges instruction fault flags, local
// address-error checks and masked interrupts into one prioritised exception
// code for CP0. It also synchronises the external interrupt lines, tracks the
// delay-slot state and holds off interrupts briefly after Status/Cause writes.
module exc_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MTC0_BLOCK  = 1
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        mem_valid,
  input  logic        stall_i,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_branch,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_eret,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [5:0]  ext_int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  output logic [4:0]  exccode_o,
  output logic [31:0] exc_badvaddr_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic [5:0]  int_o,
  output logic        mem_kill_o
);

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam int BW = (MTC0_BLOCK < 1) ? 1 : $clog2(MTC0_BLOCK + 1);

  logic [5:0][SYNC_STAGES-1:0] sync_q;
  logic [5:0]                  sync_out;
  logic                        dly_q, dly_d;
  logic [BW-1:0]               blk_q, blk_d;

  logic        take, int_ok, mis, mtc0_sr;
  logic [4:0]  code;
  logic [31:0] bad;

  // Bits of Status/Cause that play no part in exception selection.
  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  // Per-line synchroniser chains, shifting towards the MSB.
  for (genvar b = 0; b < 6; b++) begin : g_sync
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) sync_q[b] <= '0;
      else if (SYNC_STAGES > 1)
        sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], ext_int_i[b]};
      else
        sync_q[b] <= ext_int_i[b];
    end
    assign sync_out[b] = sync_q[b][SYNC_STAGES-1];
  end

  assign take    = mem_valid & ~stall_i;
  assign int_ok  = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8])) &
                   (blk_q == '0);
  assign mis     = ((mem_size == 2'b01) & mem_addr[0]) |
                   ((mem_size == 2'b10) & (mem_addr[1:0] != 2'b00));
  assign mtc0_sr = cp0_we_i & ((cp0_waddr_i == 5'd12) | (cp0_waddr_i == 5'd13));

  // Priority selection of the exception code and its bad address.
  always_comb begin
    code = EXC_NONE;
    bad  = '0;
    if (take) begin
      if (int_ok)                       code = EXC_INT;
      else if (mem_pc[1:0] != 2'b00) begin code = EXC_ADEL; bad = mem_pc; end
      else if (exc_ri)                  code = EXC_RI;
      else if (exc_ov)                  code = EXC_OV;
      else if (exc_sys)                 code = EXC_SYS;
      else if (exc_bp)                  code = EXC_BP;
      else if (exc_eret)                code = EXC_ERET;
      else if (mis & mem_re) begin      code = EXC_ADEL; bad = mem_addr; end
      else if (mis & mem_we) begin      code = EXC_ADES; bad = mem_addr; end
    end
  end

  // Next-state for delay-slot flag and MTC0 hold-off counter.
  always_comb begin
    dly_d = dly_q;
    blk_d = (blk_q != '0) ? blk_q - 1'b1 : '0;
    if (take) dly_d = (code == EXC_NONE) ? mem_is_branch : 1'b0;
    if (take & mtc0_sr & (code == EXC_NONE)) blk_d = BW'(MTC0_BLOCK);
  end

  // State registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dly_q <= 1'b0;
      blk_q <= '0;
    end else begin
      dly_q <= dly_d;
      blk_q <= blk_d;
    end
  end

  // Outputs are forced quiet while reset is held, including the
  // combinational paths from the pipeline and timer.
  assign exccode_o      = cpu_rst_n ? code : EXC_NONE;
  assign exc_badvaddr_o = cpu_rst_n ? bad : '0;
  assign pc_o           = cpu_rst_n ? mem_pc : '0;
  assign in_delay_o     = dly_q;
  assign int_o          = cpu_rst_n ? {sync_out[5] | timer_int_i, sync_out[4:0]} : '0;
  assign mem_kill_o     = cpu_rst_n & (code != EXC_NONE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: table of single-cycle vectors plus
// hand sequences for reset, delay slot, interrupt sync and MTC0 hold-off.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, stall, mem_is_branch;
  logic [31:0] mem_pc, mem_addr, status, cause;
  logic        ri, ov, sys, bp, eret, re, we, timer, cp0_we;
  logic [1:0]  size;
  logic [5:0]  ext_int;
  logic [4:0]  cp0_waddr;
  logic [4:0]  exccode;
  logic [31:0] badv, pc_o;
  logic        in_delay, kill;
  logic [5:0]  int_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.SYNC_STAGES(2), .MTC0_BLOCK(1)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .mem_valid(mem_valid), .stall_i(stall),
    .mem_pc(mem_pc), .mem_is_branch(mem_is_branch), .exc_ri(ri), .exc_ov(ov),
    .exc_sys(sys), .exc_bp(bp), .exc_eret(eret), .mem_re(re), .mem_we(we),
    .mem_size(size), .mem_addr(mem_addr), .ext_int_i(ext_int), .timer_int_i(timer),
    .status_i(status), .cause_i(cause), .cp0_we_i(cp0_we), .cp0_waddr_i(cp0_waddr),
    .exccode_o(exccode), .exc_badvaddr_o(badv), .pc_o(pc_o), .in_delay_o(in_delay),
    .int_o(int_o), .mem_kill_o(kill)
  );

  typedef struct {
    logic [4:0]  code;
    logic [31:0] bad;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        valid, stall, ri, ov, sys, bp, eret, re, we;
    logic [1:0]  size;
    logic [31:0] pc, addr;
    logic [4:0]  code;
    logic [31:0] bad;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    mem_valid = 0; stall = 0; mem_is_branch = 0; mem_pc = 32'h0; mem_addr = 32'h0;
    ri = 0; ov = 0; sys = 0; bp = 0; eret = 0; re = 0; we = 0; size = 2'b10;
    timer = 0; cp0_we = 0; cp0_waddr = 5'd0;
  endtask

  // Expected result queued when stimulus is driven.
  task automatic expect_out(input logic [4:0] c, input logic [31:0] b);
    exp_t e;
    e.code = c; e.bad = b; e.pc = mem_pc;
    sb.push_back(e);
  endtask

  // Pop and compare against the current combinational outputs.
  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    chk({name, ".code"}, {27'd0, exccode}, {27'd0, e.code});
    chk({name, ".bad"}, badv, e.bad);
    chk({name, ".kill"}, {31'd0, kill}, {31'd0, e.code != 5'h10});
    chk({name, ".pc"}, pc_o, e.pc);
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    ext_int = 6'h0; status = 32'h0; cause = 32'h0;

    // Reset state with live inputs that would otherwise raise Sys.
    rst_n = 0; mem_valid = 1; sys = 1; mem_pc = 32'h40; timer = 1;
    #3;
    expect_out(5'h10, 32'h0);
    sb[0].pc = 32'h0;
    check_out("reset");
    chk("reset.in_delay", {31'd0, in_delay}, 32'd0);
    chk("reset.int", {26'd0, int_o}, 32'd0);
    #4; rst_n = 1; timer = 0; #1;
    expect_out(5'h08, 32'h0);
    check_out("reset_rel");
    step();

    // Single-cycle vectors, no interrupts enabled.
    vt[0]  = '{1,0,1,1,0,1,0,0,0,2'b10,32'h1000,32'h0,   5'h0a,32'h0};
    vt[1]  = '{1,0,1,1,0,1,0,0,0,2'b10,32'h1002,32'h0,   5'h04,32'h1002};
    vt[2]  = '{1,0,0,0,0,0,0,0,1,2'b10,32'h1000,32'h2006,5'h05,32'h2006};
    vt[3]  = '{1,0,0,0,0,0,0,1,0,2'b01,32'h1000,32'h2006,5'h10,32'h0};
    vt[4]  = '{1,0,0,0,0,0,0,1,0,2'b01,32'h1000,32'h2007,5'h04,32'h2007};
    vt[5]  = '{1,0,0,0,0,0,0,1,0,2'b00,32'h1000,32'h2007,5'h10,32'h0};
    vt[6]  = '{1,0,0,0,1,1,0,0,0,2'b10,32'h1004,32'h0,   5'h08,32'h0};
    vt[7]  = '{1,0,0,0,0,1,1,0,0,2'b10,32'h1008,32'h0,   5'h09,32'h0};
    vt[8]  = '{1,0,0,0,0,0,1,0,1,2'b10,32'h100c,32'h2001,5'h11,32'h0};
    vt[9]  = '{1,1,1,0,0,0,0,0,0,2'b10,32'h1010,32'h0,   5'h10,32'h0};
    vt[10] = '{0,0,1,0,0,0,0,0,0,2'b10,32'h1014,32'h0,   5'h10,32'h0};
    vt[11] = '{1,0,0,1,1,0,0,0,0,2'b10,32'h1018,32'h0,   5'h0c,32'h0};
    foreach (vt[i]) begin
      idle();
      mem_valid = vt[i].valid; stall = vt[i].stall; ri = vt[i].ri; ov = vt[i].ov;
      sys = vt[i].sys; bp = vt[i].bp; eret = vt[i].eret; re = vt[i].re; we = vt[i].we;
      size = vt[i].size; mem_pc = vt[i].pc; mem_addr = vt[i].addr;
      expect_out(vt[i].code, vt[i].bad);
      #2;
      check_out($sformatf("vec%0d", i));
      step();
    end

    // Delay slot survives a bubble, then clears after the faulting slot.
    idle(); mem_valid = 1; mem_pc = 32'h100; mem_is_branch = 1;
    step();
    idle();
    #2; chk("dly.bubble", {31'd0, in_delay}, 32'd1);
    step();
    idle(); mem_valid = 1; mem_pc = 32'h104; ov = 1;
    expect_out(5'h0c, 32'h0);
    #2; check_out("dly.ov");
    chk("dly.slot", {31'd0, in_delay}, 32'd1);
    step();
    idle(); mem_valid = 1; mem_pc = 32'h108;
    #2; chk("dly.after", {31'd0, in_delay}, 32'd0);
    step();

    // Interrupt synchronisation and recognition.
    idle(); status = 32'h0000_8001; ext_int = 6'h20;
    step();
    chk("int.1edge", {26'd0, int_o}, 32'd0);
    step();
    chk("int.2edge", {26'd0, int_o}, 32'h20);
    cause = 32'h0000_8000;
    stall = 1; mem_valid = 1; mem_pc = 32'h200;
    expect_out(5'h10, 32'h0);
    #2; check_out("int.stall");
    step();
    stall = 0;
    expect_out(5'h00, 32'h0);
    #2; check_out("int.take");
    status = 32'h0000_8003;
    expect_out(5'h10, 32'h0);
    #1; check_out("int.exl");
    step();
    ext_int = 6'h0; cause = 32'h0; status = 32'h0; idle();
    step(); step();
    chk("int.cleared", {26'd0, int_o}, 32'd0);
    timer = 1; #1;
    chk("int.timer", {26'd0, int_o}, 32'h20);
    timer = 0;
    step();

    // MTC0 to Status arms the hold-off; interrupt waits one cycle.
    idle(); status = 32'h0000_8000; cause = 32'h0000_8000;
    mem_valid = 1; mem_pc = 32'h300; cp0_we = 1; cp0_waddr = 5'd12;
    expect_out(5'h10, 32'h0);
    #2; check_out("mtc0.write");
    step();
    cp0_we = 0; status = 32'h0000_8001; mem_pc = 32'h304;
    expect_out(5'h10, 32'h0);
    #2; check_out("mtc0.block");
    step();
    mem_pc = 32'h308;
    expect_out(5'h00, 32'h0);
    #2; check_out("mtc0.release");
    step();

    // MTC0 that faults does not arm the hold-off.
    status = 32'h0000_8000; mem_pc = 32'h30c; cp0_we = 1; cp0_waddr = 5'd13; sys = 1;
    expect_out(5'h08, 32'h0);
    #2; check_out("mtc0.fault");
    step();
    sys = 0; cp0_we = 0; status = 32'h0000_8001; mem_pc = 32'h310;
    expect_out(5'h00, 32'h0);
    #2; check_out("mtc0.noarm");
    step();

    // MTC0 to another register does not arm either.
    status = 32'h0000_8000; mem_pc = 32'h314; cp0_we = 1; cp0_waddr = 5'd11;
    step();
    cp0_we = 0; status = 32'h0000_8001; mem_pc = 32'h318;
    expect_out(5'h00, 32'h0);
    #2; check_out("mtc0.otherreg");
    step();

    // Reset mid-stream clears the delay-slot flag.
    idle(); status = 32'h0; cause = 32'h0; mem_valid = 1; mem_pc = 32'h400; mem_is_branch = 1;
    step();
    #2; chk("rst.dly_set", {31'd0, in_delay}, 32'd1);
    rst_n = 0; #1;
    chk("rst.dly_clr", {31'd0, in_delay}, 32'd0);
    #1; rst_n = 1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
